// File: rtl/nand_response_checker.sv
// Purpose : sweeps every input vector into a three-input NAND DUT and checks both outputs against ~&vec.
// Latency : each vector is held SETTLE+1 cycles; done rises 2**N_IN*(SETTLE+1) cycles after busy.
// Backpressure: none; start is accepted only in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start            sweep request pulse
//   vec_out          vector to the DUT (MSB = a, LSB = c)
//   dut_d, dut_e     DUT outputs under test
//   busy, done, pass sweep status; pass is meaningful while done=1
//   err_count        number of mismatching vectors
//   first_err_vec    first mismatching vector, first_err_valid marks it captured
module nand_response_checker #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_d,
    input  logic            dut_e,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [N_IN-1:0]   vec_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [N_IN:0]     err_q;
    logic [N_IN:0]     err_d;
    logic [N_IN-1:0]   fev_q;
    logic              fevld_q;
    logic              exp_val;
    logic              mism;

    // Case-inequality so an undriven or X output from the DUT is flagged in simulation.
    always_comb begin
        exp_val = ~&vec_q;
        mism    = (dut_d !== exp_val) || (dut_e !== exp_val);
        err_d   = err_q + {{N_IN{1'b0}}, mism};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= '0;
            fevld_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_q   <= '0;
                        fev_q   <= '0;
                        fevld_q <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        vec_q   <= '0;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    // err_d cannot wrap: at most 2**N_IN increments into N_IN+1 bits.
                    err_q <= err_d;
                    if (mism && !fevld_q) begin
                        fev_q   <= vec_q;
                        fevld_q <= 1'b1;
                    end
                    if (&vec_q) begin
                        // busy falls and done rises on the same edge.
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        vec_q   <= vec_q + 1'b1;
                        cnt_q   <= CNT_LOAD;
                        state_q <= S_SETTLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign vec_out         = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fevld_q;

endmodule

// File: tb/tb_nand_response_checker.sv
// Purpose : directed bench for nand_response_checker, default SETTLE and SETTLE=1 instances.
// Latency : sweeps of 168 and 16 cycles from busy to done.
// Backpressure: n/a; stimulus drives start/rst_n and emulates faulty DUTs.
module tb_nand_response_checker;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_w;
    logic [2:0] vec_w [2];
    logic [1:0] dd;
    logic [1:0] ee;
    logic [1:0] busy_w;
    logic [1:0] done_w;
    logic [1:0] pass_w;
    logic [3:0] err_w [2];
    logic [2:0] fev_w [2];
    logic [1:0] fevld_w;
    int         mode [2];

    int total;
    int bad;

    nand_response_checker #(.N_IN(3), .SETTLE(20)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .vec_out(vec_w[0]),
        .dut_d(dd[0]), .dut_e(ee[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_count(err_w[0]), .first_err_vec(fev_w[0]),
        .first_err_valid(fevld_w[0])
    );

    nand_response_checker #(.N_IN(3), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .vec_out(vec_w[1]),
        .dut_d(dd[1]), .dut_e(ee[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_count(err_w[1]), .first_err_vec(fev_w[1]),
        .first_err_valid(fevld_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Emulated gate under test: 0 golden, 1 d stuck-at-1, 2 e stuck-at-0, 3 both inverted.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic g;
            g = ~&vec_w[i];
            case (mode[i])
                1:       begin dd[i] = 1'b1; ee[i] = g;    end
                2:       begin dd[i] = g;    ee[i] = 1'b0; end
                3:       begin dd[i] = ~g;   ee[i] = ~g;   end
                default: begin dd[i] = g;    ee[i] = g;    end
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulses start, then follows the sweep until done (bounded), checking the vector
    // sequence and busy every cycle. poke_at >= 0 pulses start again mid-sweep.
    task automatic run_sweep(input int inst, input int settle, input int poke_at,
                             output int cyc, output int seq_ok);
        int c;
        seq_ok = 1;
        @(posedge clk); #1;
        start_w[inst] = 1'b1;
        @(posedge clk); #1;
        start_w[inst] = 1'b0;
        c = 0;
        while (!done_w[inst] && c < 2000) begin
            if (int'(vec_w[inst]) != c / (settle + 1) || !busy_w[inst]) seq_ok = 0;
            start_w[inst] = (c == poke_at);
            @(posedge clk); #1;
            c++;
        end
        start_w[inst] = 1'b0;
        cyc = c;
    endtask

    typedef struct {
        int m;
        int err;
        int fvec;
        int fvld;
        int pss;
    } vec_rec_t;

    vec_rec_t tbl [4];

    initial begin
        int cyc;
        int ok;

        tbl[0] = '{m: 0, err: 0, fvec: 0, fvld: 0, pss: 1};
        tbl[1] = '{m: 1, err: 1, fvec: 7, fvld: 1, pss: 0};
        tbl[2] = '{m: 2, err: 7, fvec: 0, fvld: 1, pss: 0};
        tbl[3] = '{m: 3, err: 8, fvec: 0, fvld: 1, pss: 0};

        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        start_w    = 2'b00;
        mode[0]    = 0;
        mode[1]    = 0;

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_vec",   int'(vec_w[i]), 0);
            chk("rst_busy",  int'(busy_w[i]), 0);
            chk("rst_done",  int'(done_w[i]), 0);
            chk("rst_pass",  int'(pass_w[i]), 0);
            chk("rst_err",   int'(err_w[i]), 0);
            chk("rst_fev",   int'(fev_w[i]), 0);
            chk("rst_fevld", int'(fevld_w[i]), 0);
        end
        rst_n = 1'b1;

        // Table of full sweeps with different faulty gates; later rows restart from DONE.
        for (int k = 0; k < 4; k++) begin
            mode[0] = tbl[k].m;
            run_sweep(0, 20, -1, cyc, ok);
            chk("sweep_cycles", cyc, 168);
            chk("sweep_seq",    ok, 1);
            chk("sweep_done",   int'(done_w[0]), 1);
            chk("sweep_busy",   int'(busy_w[0]), 0);
            chk("sweep_err",    int'(err_w[0]), tbl[k].err);
            chk("sweep_fev",    int'(fev_w[0]), tbl[k].fvec);
            chk("sweep_fevld",  int'(fevld_w[0]), tbl[k].fvld);
            chk("sweep_pass",   int'(pass_w[0]), tbl[k].pss);
            chk("sweep_vec",    int'(vec_w[0]), 7);
        end

        // start pulsed during vector 2 must not disturb the sweep.
        mode[0] = 0;
        run_sweep(0, 20, 2 * 21 + 5, cyc, ok);
        chk("poke_cycles", cyc, 168);
        chk("poke_seq",    ok, 1);
        chk("poke_pass",   int'(pass_w[0]), 1);

        // Reset during vector 4 aborts; a fresh sweep starts from vector 0.
        @(posedge clk); #1;
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        repeat (4 * 21 + 3) @(posedge clk);
        #1;
        chk("pre_abort_vec", int'(vec_w[0]), 4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_vec",   int'(vec_w[0]), 0);
        chk("abort_busy",  int'(busy_w[0]), 0);
        chk("abort_done",  int'(done_w[0]), 0);
        chk("abort_fevld", int'(fevld_w[0]), 0);
        mode[0] = 1;
        run_sweep(0, 20, -1, cyc, ok);
        chk("resweep_cycles", cyc, 168);
        chk("resweep_seq",    ok, 1);
        chk("resweep_err",    int'(err_w[0]), 1);
        chk("resweep_fev",    int'(fev_w[0]), 7);

        // SETTLE=1 instance: 16-cycle sweep, then restart from DONE clears status at once.
        mode[1] = 2;
        run_sweep(1, 1, -1, cyc, ok);
        chk("s1_cycles", cyc, 16);
        chk("s1_seq",    ok, 1);
        chk("s1_err",    int'(err_w[1]), 7);
        chk("s1_pass",   int'(pass_w[1]), 0);
        @(posedge clk); #1;
        start_w[1] = 1'b1;
        @(posedge clk); #1;
        start_w[1] = 1'b0;
        chk("s1_restart_err",   int'(err_w[1]), 0);
        chk("s1_restart_done",  int'(done_w[1]), 0);
        chk("s1_restart_busy",  int'(busy_w[1]), 1);
        chk("s1_restart_fevld", int'(fevld_w[1]), 0);
        cyc = 0;
        while (!done_w[1] && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("s1_restart_cycles", cyc, 16);
        chk("s1_restart_err2",   int'(err_w[1]), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // busy and done are mutually exclusive after reset has been applied.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (busy_w[i] && done_w[i]) begin
                    total++;
                    bad++;
                    $display("FAIL busy_done_overlap: inst %0d busy=1 done=1 required not both", i);
                end
            end
        end
    end

endmodule
